// File: rtl/fifo_wr_arbiter_if.sv
// Producer and FIFO write-side signals of the round-robin write arbiter.
// slave is the arbiter's view; master is the view of whoever drives producers and the FIFO.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          busy;
    logic [CNT_WIDTH-1:0]          retry_cnt;

    modport slave (
        input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        output gnt, fifo_wr_en, fifo_data_in, busy, retry_cnt
    );

    modport master (
        output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        input  gnt, fifo_wr_en, fifo_data_in, busy, retry_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port: issue one word, check the FIFO's
// acknowledge, then grant the producer or count a retry. At most one write every 3 cycles.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus_if
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic                   wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [CNT_WIDTH-1:0]   retry_q, retry_d;

    logic [FIFO_WIDTH-1:0]  slice    [NUM_REQ];
    logic [IDX_W-1:0]       cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]     cand_req;
    logic                   win_found;
    logic [IDX_W-1:0]       winner;

    logic                   ack_ok;
    logic                   overflow_nak;
    logic                   silent_nak;
    logic                   attempt_failed;

    // cand_idx[gi] is the requester gi places after ptr, so cand_req is req rotated by ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [IDX_W:0] sum;

            assign slice[gi]    = bus_if.req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
            assign sum          = {1'b0, ptr_q} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_REQ_EXT) ? IDX_W'(sum - NUM_REQ_EXT)
                                                       : sum[IDX_W-1:0];
            assign cand_req[gi] = bus_if.req[cand_idx[gi]];
        end
    endgenerate

    // Lowest rotated position wins, so scan from the far end and let nearer hits overwrite.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                win_found = 1'b1;
                winner    = cand_idx[i];
            end
        end
    end

    // An ack wins over a simultaneous overflow; both failure causes count as one retry.
    assign ack_ok         = bus_if.fifo_wr_ack;
    assign overflow_nak   = bus_if.fifo_overflow & ~bus_if.fifo_wr_ack;
    assign silent_nak     = ~bus_if.fifo_overflow & ~bus_if.fifo_wr_ack;
    assign attempt_failed = overflow_nak | silent_nak;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        wr_en_d = 1'b0;
        data_d  = data_q;
        gnt_d   = '0;
        retry_d = retry_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found && !bus_if.fifo_full) begin
                    win_d   = winner;
                    data_d  = slice[winner];
                    wr_en_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (ack_ok) begin
                    gnt_d[win_q] = 1'b1;
                    ptr_d        = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
                end else if (attempt_failed) begin
                    retry_d = (retry_q == '1) ? retry_q : retry_q + CNT_WIDTH'(1);
                    ptr_d   = win_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            gnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            retry_q <= retry_d;
        end
    end

    assign bus_if.gnt          = gnt_q;
    assign bus_if.fifo_wr_en   = wr_en_q;
    assign bus_if.fifo_data_in = data_q;
    assign bus_if.busy         = (state_q != ST_IDLE);
    assign bus_if.retry_cnt    = retry_q;

endmodule
